// File: rtl/seq_mult_unit.sv
// Multi-cycle shift-and-add multiplier for MULT/MULTU in the EX stage.
// One WIDTH-bit add per iteration. The start/busy/done handshake lets the hazard unit stall.
module seq_mult_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] phi_q, phi_d;
  logic [WIDTH-1:0] plo_q, plo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag_c, b_mag_c, addend_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    shift_c, result_c;

  // Operand magnitudes; -2^(WIDTH-1) maps onto itself, which is correct read as unsigned.
  assign a_mag_c = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag_c = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // Ripple add with carry-in 0; the carry-out is bit WIDTH of sum_c.
  assign addend_c = plo_q[0] ? m_q : '0;
  assign sum_c    = {1'b0, phi_q} + {1'b0, addend_c};

  // {carry, sum, P_lo} shifted right by one bit. The vacated top bit is always zero.
  assign shift_c  = {sum_c[WIDTH:1], sum_c[0], plo_q[WIDTH-1:1]};
  assign result_c = neg_q ? (~shift_c + PW'(1)) : shift_c;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          m_d     = a_mag_c;
          plo_d   = b_mag_c;
          phi_d   = '0;
          neg_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        phi_d = shift_c[PW-1:WIDTH];
        plo_d = shift_c[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          hi_d    = result_c[PW-1:WIDTH];
          lo_d    = result_c[WIDTH-1:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Self-checking bench for seq_mult_unit: directed corner cases plus randomized operands
// checked against a 64-bit arithmetic reference.
module tb_seq_mult_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  logic [63:0]  prev_exp;

  always #5 clk = ~clk;

  seq_mult_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .signed_op(signed_op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference product computed with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_mul(input bit sg, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (sg) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
    end else begin
      sx = {32'b0, x};
      sy = {32'b0, y};
    end
    return 64'(sx * sy);
  endfunction

  task automatic start_op(input bit sg, input logic [31:0] av, input logic [31:0] bv);
    signed_op = sg;
    a         = av;
    b         = bv;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // mode 0: quiet inputs, 1: random input noise during RUN, 2: ignored start at iteration 5.
  task automatic finish_op(input string tag, input logic [63:0] exp, input int mode,
                           input bit hold_chk, input logic [63:0] hold, input bit chk_drop);
    int cyc;
    int bcnt;
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      if (mode == 1) begin
        start     = 1'($urandom_range(0, 1));
        a         = $urandom;
        b         = $urandom;
        signed_op = 1'($urandom_range(0, 1));
      end else if (mode == 2 && cyc == 4) begin
        start = 1'b1;
        a     = 32'h55;
        b     = 32'h3;
      end else if (mode == 2 && cyc == 5) begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
      end
      step();
      cyc++;
      if (busy) bcnt++;
      if (hold_chk && busy) chk({tag, "_hold"}, {hi, lo}, hold);
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'd32);
    chk({tag, "_busycyc"}, 64'(bcnt), 64'd32);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_prod"}, {hi, lo}, exp);
    if (chk_drop) begin
      step();
      chk({tag, "_drop"}, 64'(done), 64'd0);
      chk({tag, "_keep"}, {hi, lo}, exp);
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int dc;
    dc = 0;
    repeat (n) begin
      step();
      if (done) dc++;
    end
    chk({tag, "_nodone"}, 64'(dc), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic        sg;
    logic [31:0] x, y;
    logic [63:0] e;

    rst = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    step();

    // start coinciding with reset must not be accepted
    rst = 1'b1; start = 1'b1; a = 32'd5; b = 32'd6;
    step();
    rst = 1'b0; start = 1'b0;
    step();
    chk("rst_start_busy", 64'(busy), 64'd0);
    chk("rst_start_done", 64'(done), 64'd0);

    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 64'hFFFF_FFFE_0000_0001, 0, 1'b0, '0, 1'b1);
    start_op(1'b1, 32'hFFFF_FFFD, 32'h7);
    finish_op("mult_neg3x7", 64'hFFFF_FFFF_FFFF_FFEB, 0, 1'b0, '0, 1'b1);
    start_op(1'b0, 32'hFFFF_FFFD, 32'h7);
    finish_op("multu_3x7", 64'h0000_0006_FFFF_FFEB, 0, 1'b0, '0, 1'b1);
    start_op(1'b1, 32'h8000_0000, 32'h8000_0000);
    finish_op("mult_minmin", 64'h4000_0000_0000_0000, 0, 1'b0, '0, 1'b1);
    start_op(1'b1, 32'h8000_0000, 32'h1);
    finish_op("mult_minx1", 64'hFFFF_FFFF_8000_0000, 0, 1'b0, '0, 1'b1);

    start_op(1'b0, 32'd12, 32'd10);
    finish_op("ign_start", 64'h78, 2, 1'b0, '0, 1'b1);
    quiet("ign_start", 40);

    // reset in the middle of a run aborts it
    start_op(1'b0, 32'd7, 32'd9);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    quiet("abort", 40);

    start_op(1'b0, 32'd5, 32'd0);
    finish_op("zero", 64'd0, 0, 1'b0, '0, 1'b1);

    // back-to-back: a new start accepted in the done cycle
    start_op(1'b0, 32'd3, 32'd4);
    finish_op("b2b_first", 64'hC, 0, 1'b0, '0, 1'b0);
    signed_op = 1'b0; a = 32'd6; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_done_drop", 64'(done), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd1);
    finish_op("b2b_second", 64'h2A, 0, 1'b1, 64'hC, 1'b1);
    prev_exp = 64'h2A;

    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: x = 32'h0;
        1: x = 32'h8000_0000;
        2: x = 32'hFFFF_FFFF;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: y = 32'h1;
        1: y = 32'h8000_0000;
        2: y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      e = ref_mul(sg, x, y);
      start_op(sg, x, y);
      finish_op("rnd", e, 1, 1'b1, prev_exp, 1'b1);
      prev_exp = e;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
